pc_offset_unit: RTL and testbench
=================================

Name: pc_offset_unit

Overview:
- Parametrised successor to the 2-bit branch-offset sign extender.
- Sign-extends an IMM_W-bit branch field to ADDR_W bits and registers it.
- Owns the program counter: holds, increments, branches by the extended offset, or loads an absolute address.
- Sits between the instruction decoder and instruction memory address port; a small FSM adds boot/halt sequencing.

Parameters:
- IMM_W, 2, width of the signed branch immediate (>=2, <=ADDR_W).
- ADDR_W, 8, width of PC and extended offset.
- RESET_PC, 0, PC value after reset (ADDR_W bits).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  advance enable; PC only changes on cycles with en=1 (except load in HALT).
- branch  input  1  take branch this cycle.
- imm  input  IMM_W  signed branch immediate.
- load  input  1  absolute jump request.
- load_addr  input  ADDR_W  jump target.
- halt  input  1  request freeze.
- pc  output  ADDR_W  current program counter (registered).
- offset  output  ADDR_W  registered sign-extended imm.
- pc_valid  output  1  high when pc is a fetchable address (state RUN).
- halted  output  1  high in state HALT.
- wrap  output  1  sticky PC wrap-around flag (optional feature).

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, offset=0, pc_valid=0, halted=0, wrap=0, state=BOOT.
- offset: on every clk edge with en=1, offset <= {replicate imm[IMM_W-1], imm}; holds when en=0. Latency 1. For IMM_W=2/ADDR_W=8: 00->0x00, 01->0x01, 10->0xFE, 11->0xFF.
- sext(imm) used for the PC update is the combinational extension of the current imm, not the registered offset.
- States: BOOT, RUN, HALT.
- BOOT: lasts exactly one cycle after reset release; pc held at RESET_PC; inputs ignored; -> RUN. pc_valid=0.
- RUN: pc_valid=1. If en=1, PC update priority is load > branch > increment:
  - load: pc <= load_addr.
  - branch: pc <= pc + 1 + sext(imm).
  - else: pc <= pc + 1.
  - All arithmetic modulo 2^ADDR_W.
  - If en=0, pc holds.
  - halt=1 -> HALT next cycle; the update on that same cycle still applies if en=1.
- HALT: halted=1, pc_valid=0, pc frozen regardless of en/branch.
  - load=1: pc <= load_addr, -> RUN (priority over halt).
  - else if halt=0: -> RUN with pc unchanged.
- Simultaneous load+branch: load wins; branch ignored.
- branch with imm=all-ones (-1): pc unchanged (self-loop). This is a legal, stable state.
- Reset asserted mid-operation: immediate return to reset values; the FSM restarts in BOOT.

Optional Feature:
- Macro: PC_WRAP_FLAG_EN.
- Defined: wrap sets (sticky) when an increment or branch update carries out of or borrows below ADDR_W bits, i.e. the unsigned result differs from the true signed sum. A load clears it; a load in the same cycle as a wrapping event leaves wrap=0. Reset clears it.
- Undefined: wrap tied to 0 and no wrap logic is synthesised.

Test Plan:
- Reset/boot: rst_n low then high, en=1 -> pc=0x00, pc_valid=0 for 1 cycle, then pc=0x01, 0x02, 0x03 on successive cycles.
- Offset table: imm=00,01,10,11 with en=1 -> offset=0x00, 0x01, 0xFE, 0xFF one cycle later.
- Branch: pc=0x10, branch=1, imm=10 -> pc=0x0F. Then imm=11 -> pc stays 0x0F for repeated cycles.
- Priority: pc=0x20, load=1, load_addr=0x80, branch=1, imm=01 -> pc=0x80.
- Halt/resume: in RUN, halt=1 at pc=0x05 with en=1 -> pc=0x06, halted=1, pc_valid=0, and pc stays 0x06. halt=0 -> RUN, next en cycle pc=0x07. In HALT, load=1, load_addr=0x40 -> pc=0x40, RUN.
- Wrap (PC_WRAP_FLAG_EN):
  - pc=0xFF, increment -> pc=0x00, wrap=1, and it stays 1.
  - load 0x10 -> wrap=0.
  - pc=0x00, branch imm=10 -> pc=0xFF, wrap=1.
  - Without the macro, wrap=0 throughout.

Source files
------------

// File: rtl/pc_offset_unit_if.sv
// pc_offset_unit_if: decoder-side control and PC/offset results for pc_offset_unit
interface pc_offset_unit_if #(parameter int IMM_W = 2, parameter int ADDR_W = 8);
  logic en, branch, load, halt;
  logic [IMM_W-1:0] imm;
  logic [ADDR_W-1:0] load_addr, pc, offset;
  logic pc_valid, halted, wrap;
  modport master (output en, branch, imm, load, load_addr, halt,
                  input pc, offset, pc_valid, halted, wrap);
  modport slave (input en, branch, imm, load, load_addr, halt,
                 output pc, offset, pc_valid, halted, wrap);
endinterface

// File: rtl/pc_offset_unit.sv
// pc_offset_unit: program counter with registered sign-extended branch offset and BOOT/RUN/HALT sequencing
// Optional sticky wrap-around flag enabled by defining PC_WRAP_FLAG_EN.
module pc_offset_unit #(
  parameter int IMM_W = 2,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst_n,
  pc_offset_unit_if.slave bus
);
`ifdef PC_WRAP_FLAG_EN
  localparam int SW = ADDR_W + 2;
`else
  localparam int SW = ADDR_W;
`endif
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, r_offset, w_pc_nxt;
  logic [SW-1:0] w_sum;
  logic w_run, w_hlt;
  // Two guard bits make the sum signed-exact, so any set guard bit means wrap
  assign w_sum = SW'(r_pc) + SW'(1) + (bus.branch ? SW'($signed(bus.imm)) : SW'(0));
  assign w_run = r_state == RUN;
  assign w_hlt = r_state == HALT;
  always_comb begin
    w_pc_nxt = (w_run && bus.en) ? (bus.load ? bus.load_addr : w_sum[ADDR_W-1:0]) :
               (w_hlt && bus.load) ? bus.load_addr : r_pc;
    w_state_nxt = w_run ? (bus.halt ? HALT : RUN) :
                  w_hlt ? ((bus.load || !bus.halt) ? RUN : HALT) : RUN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
      r_pc <= RESET_PC;
      r_offset <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc <= w_pc_nxt;
      if (bus.en) r_offset <= ADDR_W'($signed(bus.imm));
    end
  end
`ifdef PC_WRAP_FLAG_EN
  logic r_wrap;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wrap <= 1'b0;
    else if (w_run && bus.en) r_wrap <= bus.load ? 1'b0 : (r_wrap | (|w_sum[SW-1:ADDR_W]));
    else if (w_hlt && bus.load) r_wrap <= 1'b0;
  end
  assign bus.wrap = r_wrap;
`else
  assign bus.wrap = 1'b0;
`endif
  assign bus.pc = r_pc;
  assign bus.offset = r_offset;
  assign bus.pc_valid = w_run;
  assign bus.halted = w_hlt;
endmodule

// File: tb/tb_pc_offset_unit.sv
// tb_pc_offset_unit: table-driven scoreboard bench for pc_offset_unit
module tb_pc_offset_unit;
`ifdef PC_WRAP_FLAG_EN
  localparam logic W = 1'b1;
`else
  localparam logic W = 1'b0;
`endif
  typedef struct {
    logic en, branch, load, halt;
    logic [1:0] imm;
    logic [7:0] la, pc, off;
    logic valid, halted, wrap;
  } vec_t;
  logic clk, rst_n;
  int n_cmp = 0, n_err = 0;
  vec_t sb[$];
  vec_t tbl[26];
  pc_offset_unit_if #(.IMM_W(2), .ADDR_W(8)) bus ();
  pc_offset_unit #(.IMM_W(2), .ADDR_W(8), .RESET_PC(8'h00)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic vec_t mk(int en, int br, int imm, int ld, int la, int hl,
                              int pc, int off, int v, int h, int w);
    vec_t r;
    r.en = 1'(en); r.branch = 1'(br); r.imm = 2'(imm); r.load = 1'(ld);
    r.la = 8'(la); r.halt = 1'(hl); r.pc = 8'(pc); r.off = 8'(off);
    r.valid = 1'(v); r.halted = 1'(h); r.wrap = 1'(w);
    return r;
  endfunction
  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    bus.en = v.en; bus.branch = v.branch; bus.imm = v.imm;
    bus.load = v.load; bus.load_addr = v.la; bus.halt = v.halt;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: scoreboard empty, got nothing, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk8({tag, ".pc"}, bus.pc, e.pc);
      chk8({tag, ".offset"}, bus.offset, e.off);
      chk1({tag, ".pc_valid"}, bus.pc_valid, e.valid);
      chk1({tag, ".halted"}, bus.halted, e.halted);
      chk1({tag, ".wrap"}, bus.wrap, e.wrap);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk8({tag, ".pc"}, bus.pc, 8'h00);
    chk8({tag, ".offset"}, bus.offset, 8'h00);
    chk1({tag, ".pc_valid"}, bus.pc_valid, 1'b0);
    chk1({tag, ".halted"}, bus.halted, 1'b0);
    chk1({tag, ".wrap"}, bus.wrap, 1'b0);
  endtask
  initial begin
    tbl[0]  = mk(1,0,0,0,'h00,0, 'h00,'h00,1,0,0);
    tbl[1]  = mk(1,0,0,0,'h00,0, 'h01,'h00,1,0,0);
    tbl[2]  = mk(1,0,0,0,'h00,0, 'h02,'h00,1,0,0);
    tbl[3]  = mk(1,0,0,0,'h00,0, 'h03,'h00,1,0,0);
    tbl[4]  = mk(1,0,1,0,'h00,0, 'h04,'h01,1,0,0);
    tbl[5]  = mk(1,0,2,0,'h00,0, 'h05,'hFE,1,0,0);
    tbl[6]  = mk(1,0,3,0,'h00,0, 'h06,'hFF,1,0,0);
    tbl[7]  = mk(0,0,1,0,'h00,0, 'h06,'hFF,1,0,0);
    tbl[8]  = mk(1,0,0,1,'h10,0, 'h10,'h00,1,0,0);
    tbl[9]  = mk(1,1,2,0,'h00,0, 'h0F,'hFE,1,0,0);
    tbl[10] = mk(1,1,3,0,'h00,0, 'h0F,'hFF,1,0,0);
    tbl[11] = mk(1,1,3,0,'h00,0, 'h0F,'hFF,1,0,0);
    tbl[12] = mk(0,1,2,0,'h00,0, 'h0F,'hFF,1,0,0);
    tbl[13] = mk(1,0,0,1,'h20,0, 'h20,'h00,1,0,0);
    tbl[14] = mk(1,1,1,1,'h80,0, 'h80,'h01,1,0,0);
    tbl[15] = mk(1,0,0,1,'h05,0, 'h05,'h00,1,0,0);
    tbl[16] = mk(1,0,0,0,'h00,1, 'h06,'h00,0,1,0);
    tbl[17] = mk(1,1,1,0,'h00,1, 'h06,'h01,0,1,0);
    tbl[18] = mk(0,0,0,0,'h00,1, 'h06,'h01,0,1,0);
    tbl[19] = mk(0,0,0,0,'h00,0, 'h06,'h01,1,0,0);
    tbl[20] = mk(1,0,0,0,'h00,0, 'h07,'h00,1,0,0);
    tbl[21] = mk(1,0,0,0,'h00,1, 'h08,'h00,0,1,0);
    tbl[22] = mk(0,0,0,1,'h40,1, 'h40,'h00,1,0,0);
    tbl[23] = mk(1,0,0,0,'h00,0, 'h41,'h00,1,0,0);
    tbl[24] = mk(1,1,1,0,'h00,0, 'h43,'h01,1,0,0);
    tbl[25] = mk(0,0,0,1,'h99,0, 'h43,'h01,1,0,0);
    bus.en = 1'b1; bus.branch = 1'b0; bus.imm = 2'd0;
    bus.load = 1'b0; bus.load_addr = 8'h00; bus.halt = 1'b0;
    rst_n = 1'b0;
    #12;
    chk_reset("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk1("boot.pc_valid", bus.pc_valid, 1'b0);
    chk8("boot.pc", bus.pc, 8'h00);
    for (int i = 0; i < 26; i++) apply(tbl[i], $sformatf("v%0d", i));
    apply(mk(1,0,0,1,'hFF,0, 'hFF,'h00,1,0,0), "wrap_ld_ff");
    apply(mk(1,0,0,0,'h00,0, 'h00,'h00,1,0,W), "wrap_inc");
    apply(mk(1,0,0,0,'h00,0, 'h01,'h00,1,0,W), "wrap_sticky");
    apply(mk(1,0,0,1,'h10,0, 'h10,'h00,1,0,0), "wrap_clr_ld");
    apply(mk(1,0,0,1,'h00,0, 'h00,'h00,1,0,0), "wrap_ld_00");
    apply(mk(1,1,2,0,'h00,0, 'hFF,'hFE,1,0,W), "wrap_borrow");
    apply(mk(1,0,0,1,'hFF,0, 'hFF,'h00,1,0,0), "wrap_clr2");
    apply(mk(1,0,0,1,'h30,0, 'h30,'h00,1,0,0), "wrap_ld_beats");
    apply(mk(1,0,0,1,'hFF,0, 'hFF,'h00,1,0,0), "wrap_ld_ff2");
    apply(mk(1,0,0,0,'h00,1, 'h00,'h00,0,1,W), "wrap_halt");
    apply(mk(0,0,0,1,'h05,1, 'h05,'h00,1,0,0), "wrap_halt_ld");
    apply(mk(1,1,3,0,'h00,1, 'h05,'hFF,0,1,0), "pre_rst");
    rst_n = 1'b0;
    #1;
    chk_reset("mid_reset");
    @(posedge clk);
    #1;
    chk_reset("held_reset");
    rst_n = 1'b1;
    apply(mk(1,0,0,0,'h00,0, 'h00,'h00,1,0,0), "reboot");
    apply(mk(1,0,0,0,'h00,0, 'h01,'h00,1,0,0), "reboot_inc");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
